// File: rtl/sh_rgst_ctrl.sv
// Sequencer for the downstream sh_rgst: accepts a word, pulses ld once, then sh WIDTH times, then done.
// Define SH_RGST_CTRL_PREFETCH_EN to add a one-word holding buffer so back-to-back words skip IDLE.
module sh_rgst_ctrl #(
    parameter int unsigned WIDTH = 16,
    parameter logic        FILL  = 1'b0
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] d,
    output logic             ld,
    output logic             sh,
    output logic             sh_in,
    output logic             busy,
    output logic             done
);
    localparam int unsigned      CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             accept;

`ifdef SH_RGST_CTRL_PREFETCH_EN
    logic             buf_full;
    logic [WIDTH-1:0] buf_data;
`endif

    assign accept = in_valid && in_ready;
    assign sh_in  = FILL;

    // NOTE: registers use <= so every flop samples pre-edge values; blocking assignments here would race.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: state_nxt defaults to the current state first, so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = LOAD;
            LOAD:    state_nxt = SHIFT;
            SHIFT:   if (cnt == CNT_LAST) state_nxt = DONE;
            DONE: begin
`ifdef SH_RGST_CTRL_PREFETCH_EN
                state_nxt = (buf_full || accept) ? LOAD : IDLE;
`else
                state_nxt = IDLE;
`endif
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Moore outputs; in_ready never looks at in_valid.
    always_comb begin
        ld   = (state == LOAD);
        sh   = (state == SHIFT);
        done = (state == DONE);
        busy = (state != IDLE);
`ifdef SH_RGST_CTRL_PREFETCH_EN
        in_ready = (state == IDLE) || (((state == SHIFT) || (state == DONE)) && !buf_full);
`else
        in_ready = (state == IDLE);
`endif
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            cnt <= '0;
        end else if (state == LOAD) begin
            cnt <= '0;
        end else if (state == SHIFT) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // d only moves when a new word enters LOAD, so it stays stable across the whole shift.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            d <= '0;
        end else if ((state == IDLE) && accept) begin
            d <= in_data;
`ifdef SH_RGST_CTRL_PREFETCH_EN
        end else if ((state == DONE) && buf_full) begin
            d <= buf_data;
        end else if ((state == DONE) && accept) begin
            d <= in_data;
`endif
        end
    end

`ifdef SH_RGST_CTRL_PREFETCH_EN
    // A word accepted mid-shift waits here; one accepted in DONE goes straight to d instead.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            buf_full <= 1'b0;
            buf_data <= '0;
        end else if ((state == SHIFT) && accept) begin
            buf_full <= 1'b1;
            buf_data <= in_data;
        end else if ((state == DONE) && buf_full) begin
            buf_full <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_sh_rgst_ctrl.sv
// Self-checking bench for sh_rgst_ctrl: directed and random words checked against a job-schedule model.
// Expectations follow SH_RGST_CTRL_PREFETCH_EN when it is defined for the build.
module tb_sh_rgst_ctrl;
    localparam int   W    = 16;
    localparam logic FILL = 1'b0;
`ifdef SH_RGST_CTRL_PREFETCH_EN
    localparam int EXP_GAP = W + 2;
`else
    localparam int EXP_GAP = W + 3;
`endif

    logic         clk;
    logic         rst_b;
    logic [W-1:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] d;
    logic         ld;
    logic         sh;
    logic         sh_in;
    logic         busy;
    logic         done;

    sh_rgst_ctrl #(.WIDTH(W), .FILL(FILL)) dut (
        .clk      (clk),
        .rst_b    (rst_b),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .d        (d),
        .ld       (ld),
        .sh       (sh),
        .sh_in    (sh_in),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream sh_rgst model, driven by the controller's outputs.
    logic [W-1:0] sr;
    always @(posedge clk) begin
        if (ld)      sr <= d;
        else if (sh) sr <= {sr[W-2:0], sh_in};
    end

    // Each accepted word is a job: ld at cycle start, sh for start+1..start+W, done at start+W+1.
    typedef struct {
        int           start;
        logic [W-1:0] word;
    } job_t;

    job_t         jobs[$];
    int           ld_cycles[$];
    logic [W-1:0] cur_d;
    int           cyc;
    int           tests;
    int           fails;
    int           n_ld, n_sh, n_done;
    bit           last_hs;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_ld"},    32'(ld),       32'd0);
        check({tag, "_sh"},    32'(sh),       32'd0);
        check({tag, "_done"},  32'(done),     32'd0);
        check({tag, "_busy"},  32'(busy),     32'd0);
        check({tag, "_d"},     32'(d),        32'd0);
        check({tag, "_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_shin"},  32'(sh_in),    32'(FILL));
    endtask

    task automatic model_reset();
        jobs.delete();
        cur_d  = '0;
        cyc    = 0;
        n_ld   = 0;
        n_sh   = 0;
        n_done = 0;
    endtask

    // Called just after a falling edge: check cycle cyc, drive inputs for the next rising edge.
    task automatic step(input logic v, input logic [W-1:0] data);
        bit   active;
        int   js;
        logic exp_ready;
        while (jobs.size() > 0 && jobs[0].start + W + 1 < cyc) void'(jobs.pop_front());
        active = (jobs.size() > 0) && (jobs[0].start <= cyc);
        js     = active ? jobs[0].start : -1000;
        if (active) cur_d = jobs[0].word;
`ifdef SH_RGST_CTRL_PREFETCH_EN
        exp_ready = !active || ((cyc > js) && (jobs.size() == 1));
`else
        exp_ready = !active;
`endif
        check("ld",    32'(ld),       32'(active && cyc == js));
        check("sh",    32'(sh),       32'(active && cyc > js && cyc <= js + W));
        check("done",  32'(done),     32'(active && cyc == js + W + 1));
        check("busy",  32'(busy),     32'(active));
        check("ready", 32'(in_ready), 32'(exp_ready));
        check("d",     32'(d),        32'(cur_d));
        check("sh_in", 32'(sh_in),    32'(FILL));
        if (ld) begin
            n_ld++;
            ld_cycles.push_back(cyc);
        end
        if (sh)   n_sh++;
        if (done) n_done++;
        in_valid = v;
        in_data  = data;
        last_hs  = v && exp_ready;
        if (last_hs) jobs.push_back('{active ? js + W + 2 : cyc + 1, data});
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        logic [W-1:0] words [2];
        int           idx;
        int           guard;

        words[0] = 16'hAB00;
        words[1] = 16'h1234;

        // Reset held with in_valid high: nothing may be accepted.
        rst_b    = 1'b0;
        in_valid = 1'b1;
        in_data  = 16'hAB00;
        model_reset();
        #27;
        check_idle("rst_hold");
        @(negedge clk);
        check_idle("rst_hold2");
        rst_b = 1'b1;
        model_reset();

        // Single word accepted on the first edge after release; in_data changes afterwards.
        step(1'b1, 16'hAB00);
        repeat (22) step(1'b0, 16'h1234);
        check("single_ld_cnt",   32'(n_ld),   32'd1);
        check("single_sh_cnt",   32'(n_sh),   32'(W));
        check("single_done_cnt", 32'(n_done), 32'd1);
        check("single_sr_final", 32'(sr),     32'({W{FILL}}));
        check("single_d_hold",   32'(d),      32'h0000AB00);

        // Backpressure: no valid, nothing happens.
        n_ld = 0;
        repeat (10) step(1'b0, 16'($urandom));
        check("idle_ld_cnt", 32'(n_ld), 32'd0);

        // Back-to-back with in_valid held high.
        ld_cycles.delete();
        idx   = 0;
        guard = 0;
        while (idx < 2 && guard < 60) begin
            step(1'b1, words[idx]);
            if (last_hs) idx++;
            guard++;
        end
        check("b2b_accepted", 32'(idx), 32'd2);
        repeat (45) step(1'b0, 16'h0000);
        check("b2b_ld_count", 32'(ld_cycles.size()), 32'd2);
        if (ld_cycles.size() >= 2)
            check("b2b_ld_gap", 32'(ld_cycles[1] - ld_cycles[0]), 32'(EXP_GAP));
        check("b2b_sr_final", 32'(sr), 32'({W{FILL}}));

        // Random traffic.
        repeat (200) step(1'($urandom_range(0, 2) == 0), 16'($urandom));
        repeat (45) step(1'b0, 16'h0000);

        // Reset in the middle of a shift.
        n_sh   = 0;
        n_done = 0;
        guard  = 0;
        step(1'b1, 16'h5A5A);
        while (n_sh < 5 && guard < 40) begin
            step(1'b0, 16'h0000);
            guard++;
        end
        check("mid_sh_seen", 32'(n_sh), 32'd5);
        rst_b    = 1'b0;
        in_valid = 1'b1;
        #1;
        check_idle("mid_rst");
        check("mid_no_done", 32'(n_done), 32'd0);
        @(negedge clk);
        check_idle("mid_rst_hold");
        in_valid = 1'b0;
        rst_b    = 1'b1;
        model_reset();
        step(1'b1, 16'h00FF);
        repeat (22) step(1'b0, 16'h0000);
        check("post_rst_ld_cnt",   32'(n_ld),   32'd1);
        check("post_rst_sh_cnt",   32'(n_sh),   32'(W));
        check("post_rst_done_cnt", 32'(n_done), 32'd1);
        check("post_rst_d",        32'(d),      32'h000000FF);
        check("post_rst_sr_final", 32'(sr),     32'({W{FILL}}));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
